// File: rtl/osd_pkg.sv
// Shared OSD definitions: generator latency, pixel bundle and position width.
// Imported by the mixer stage and the OSD generator.
package osd_pkg;

    localparam int OSD_GEN_LATENCY = 6;
    localparam int CH_W = 8;
    localparam int XY_W = 11;
    localparam logic [XY_W-1:0] XY_MAX = '1;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
        logic            hs;
        logic            vs;
        logic            de;
    } pixel_t;

endpackage

// File: rtl/osd_pos_counter.sv
// Active-video position counter: DE/vsync edge detect, saturating x/y counters,
// registered xpos/ypos toward the OSD generator.
module osd_pos_counter
    import osd_pkg::*;
#(
    parameter logic VS_POL = 1'b0
) (
    input  logic            vclk,
    input  logic            rst_i,
    input  logic            de_i,
    input  logic            vsync_i,
    output logic [XY_W-1:0] xpos,
    output logic [XY_W-1:0] ypos
);

    logic            de_q, de_d;
    logic            vs_act_q, vs_act_d;
    logic [XY_W-1:0] x_cnt_q, x_cnt_d;
    logic [XY_W-1:0] y_cnt_q, y_cnt_d;
    logic [XY_W-1:0] xpos_q, xpos_d;
    logic [XY_W-1:0] ypos_q, ypos_d;
    logic            vs_act;
    logic            vs_lead;
    logic            de_fall;

    always_comb begin
        vs_act   = (vsync_i == VS_POL);
        vs_lead  = vs_act & ~vs_act_q;
        de_fall  = de_q & ~de_i;
        de_d     = de_i;
        vs_act_d = vs_act;
        x_cnt_d  = x_cnt_q;
        y_cnt_d  = y_cnt_q;
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        if (de_i) begin
            xpos_d = x_cnt_q;
            ypos_d = y_cnt_q;
        end
        // vsync leading edge overrides a coincident DE fall
        if (vs_lead) begin
            x_cnt_d = '0;
            y_cnt_d = '0;
        end else if (de_i) begin
            if (x_cnt_q != XY_MAX) x_cnt_d = x_cnt_q + XY_W'(1);
        end else if (de_fall) begin
            x_cnt_d = '0;
            if (y_cnt_q != XY_MAX) y_cnt_d = y_cnt_q + XY_W'(1);
        end
    end

    always_ff @(posedge vclk or posedge rst_i) begin
        if (rst_i) begin
            de_q     <= 1'b0;
            vs_act_q <= 1'b0;
            x_cnt_q  <= '0;
            y_cnt_q  <= '0;
            xpos_q   <= '0;
            ypos_q   <= '0;
        end else begin
            de_q     <= de_d;
            vs_act_q <= vs_act_d;
            x_cnt_q  <= x_cnt_d;
            y_cnt_q  <= y_cnt_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
        end
    end

    assign xpos = xpos_q;
    assign ypos = ypos_q;

endmodule

// File: rtl/osd_video_mixer.sv
// Pixel-path stage around the OSD generator: position out, video delay to
// match generator latency, registered OSD overlay with aligned syncs.
module osd_video_mixer
    import osd_pkg::*;
#(
    parameter int   OSD_LATENCY = OSD_GEN_LATENCY,
    parameter int   BG_SHIFT    = 1,
    parameter logic VS_POL      = 1'b0,
    localparam int  COLOR_W     = CH_W
) (
    input  logic                 vclk,
    input  logic                 rst_i,
    input  logic [COLOR_W-1:0]   r_i,
    input  logic [COLOR_W-1:0]   g_i,
    input  logic [COLOR_W-1:0]   b_i,
    input  logic                 hsync_i,
    input  logic                 vsync_i,
    input  logic                 de_i,
    output logic [XY_W-1:0]      xpos,
    output logic [XY_W-1:0]      ypos,
    input  logic                 osd_enable,
    input  logic                 osd_color,
    input  logic [3*COLOR_W-1:0] fg_rgb,
    output logic [COLOR_W-1:0]   r_o,
    output logic [COLOR_W-1:0]   g_o,
    output logic [COLOR_W-1:0]   b_o,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic                 de_o
);

    localparam int DLY = OSD_LATENCY + 1;

    pixel_t             pix_in;
    pixel_t             v;
    pixel_t             dly_q [DLY];
    pixel_t             dly_d [DLY];
    logic [COLOR_W-1:0] r_q, r_d;
    logic [COLOR_W-1:0] g_q, g_d;
    logic [COLOR_W-1:0] b_q, b_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               de_q, de_d;

    osd_pos_counter #(
        .VS_POL (VS_POL)
    ) u_pos (
        .vclk    (vclk),
        .rst_i   (rst_i),
        .de_i    (de_i),
        .vsync_i (vsync_i),
        .xpos    (xpos),
        .ypos    (ypos)
    );

    // Last stage lines up with osd_enable/osd_color for the same pixel
    always_comb begin
        pix_in   = '{r: r_i, g: g_i, b: b_i, hs: hsync_i, vs: vsync_i, de: de_i};
        dly_d[0] = pix_in;
        for (int i = 1; i < DLY; i++) dly_d[i] = dly_q[i-1];
    end

    always_comb begin
        v    = dly_q[DLY-1];
        r_d  = '0;
        g_d  = '0;
        b_d  = '0;
        hs_d = v.hs;
        vs_d = v.vs;
        de_d = v.de;
        unique case (1'b1)
            !v.de: begin
            end
            v.de && !osd_enable: begin
                r_d = v.r;
                g_d = v.g;
                b_d = v.b;
            end
            v.de && osd_enable && osd_color: begin
                r_d = fg_rgb[2*COLOR_W +: COLOR_W];
                g_d = fg_rgb[COLOR_W +: COLOR_W];
                b_d = fg_rgb[0 +: COLOR_W];
            end
            v.de && osd_enable && !osd_color: begin
                r_d = v.r >> BG_SHIFT;
                g_d = v.g >> BG_SHIFT;
                b_d = v.b >> BG_SHIFT;
            end
        endcase
    end

    always_ff @(posedge vclk or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DLY; i++) dly_q[i] <= '0;
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            de_q <= 1'b0;
        end else begin
            dly_q <= dly_d;
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
        end
    end

    assign r_o     = r_q;
    assign g_o     = g_q;
    assign b_o     = b_q;
    assign hsync_o = hs_q;
    assign vsync_o = vs_q;
    assign de_o    = de_q;

endmodule

// File: tb/tb_osd_video_mixer.sv
// Self-checking bench for osd_video_mixer: randomized video/OSD stimulus
// against a behavioural model, plus directed literal checks.
module tb_osd_video_mixer;
    import osd_pkg::*;

    logic        vclk = 1'b0;
    logic        rst_i;
    logic [7:0]  r_i, g_i, b_i;
    logic        hsync_i, vsync_i, de_i;
    logic [10:0] xpos, ypos;
    logic        osd_enable, osd_color;
    logic [23:0] fg_rgb;
    logic [7:0]  r_o, g_o, b_o;
    logic        hsync_o, vsync_o, de_o;

    int checks = 0;
    int failures = 0;

    always #5 vclk = ~vclk;

    osd_video_mixer dut (
        .vclk       (vclk),
        .rst_i      (rst_i),
        .r_i        (r_i),
        .g_i        (g_i),
        .b_i        (b_i),
        .hsync_i    (hsync_i),
        .vsync_i    (vsync_i),
        .de_i       (de_i),
        .xpos       (xpos),
        .ypos       (ypos),
        .osd_enable (osd_enable),
        .osd_color  (osd_color),
        .fg_rgb     (fg_rgb),
        .r_o        (r_o),
        .g_o        (g_o),
        .b_o        (b_o),
        .hsync_o    (hsync_o),
        .vsync_o    (vsync_o),
        .de_o       (de_o)
    );

    typedef struct {
        logic [7:0] r, g, b;
        logic       hs, vs, de;
    } vpix_t;

    // Behavioural model: pixel FIFO of 7 entries, position from line/frame rules
    vpix_t       pipe[$];
    int          mx, my;
    bit          mde_p, mvs_p;
    logic [10:0] ex, ey;
    logic [7:0]  er, eg, eb;
    logic        ehs, evs, ede;

    task automatic mdl_reset();
        vpix_t z;
        z = '{r: 8'd0, g: 8'd0, b: 8'd0, hs: 1'b0, vs: 1'b0, de: 1'b0};
        pipe.delete();
        for (int i = 0; i < 7; i++) pipe.push_back(z);
        mx = 0; my = 0; mde_p = 0; mvs_p = 0;
        ex = 0; ey = 0; er = 0; eg = 0; eb = 0;
        ehs = 0; evs = 0; ede = 0;
    endtask

    task automatic mdl_edge();
        vpix_t v, cur;
        bit va, lead;
        cur = '{r: r_i, g: g_i, b: b_i, hs: hsync_i, vs: vsync_i, de: de_i};
        v = pipe.pop_front();
        pipe.push_back(cur);
        if (!v.de) begin
            er = 0; eg = 0; eb = 0;
        end else if (!osd_enable) begin
            er = v.r; eg = v.g; eb = v.b;
        end else if (osd_color) begin
            er = fg_rgb[23:16]; eg = fg_rgb[15:8]; eb = fg_rgb[7:0];
        end else begin
            er = v.r / 2; eg = v.g / 2; eb = v.b / 2;
        end
        ehs = v.hs; evs = v.vs; ede = v.de;
        va = (vsync_i == 1'b0);
        lead = va && !mvs_p;
        if (de_i) begin
            ex = 11'(mx);
            ey = 11'(my);
        end
        if (lead) begin
            mx = 0; my = 0;
        end else if (de_i) begin
            mx = (mx >= 2047) ? 2047 : mx + 1;
        end else if (mde_p) begin
            mx = 0;
            my = (my >= 2047) ? 2047 : my + 1;
        end
        mvs_p = va;
        mde_p = de_i;
    endtask

    initial begin
        mdl_reset();
        forever begin
            @(posedge vclk);
            if (rst_i) mdl_reset();
            else mdl_edge();
        end
    end

    always @(negedge vclk) begin
        if (!rst_i) begin
            checks++;
            if ({xpos, ypos, r_o, g_o, b_o, hsync_o, vsync_o, de_o} !==
                {ex, ey, er, eg, eb, ehs, evs, ede}) begin
                failures++;
                $display("FAIL pix_cmp t=%0t got x=%0d y=%0d rgb=%h%h%h s=%b%b%b exp x=%0d y=%0d rgb=%h%h%h s=%b%b%b",
                         $time, xpos, ypos, r_o, g_o, b_o, hsync_o, vsync_o, de_o,
                         ex, ey, er, eg, eb, ehs, evs, ede);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge vclk);
    endtask

    task automatic line(input int nde, input int nbl, input int exp_y, input bit vs_fall);
        fg_rgb = 24'($urandom);
        for (int k = 0; k < nde; k++) begin
            r_i = 8'($urandom); g_i = 8'($urandom); b_i = 8'($urandom);
            de_i = 1'b1; hsync_i = 1'b0; vsync_i = 1'b1;
            osd_enable = 1'($urandom); osd_color = 1'($urandom);
            step();
            if (k == 0 || k == 2047 || k == nde - 1) begin
                chk("line_xpos", 32'(xpos), (k > 2047) ? 2047 : k);
                chk("line_ypos", 32'(ypos), 32'(exp_y));
            end
        end
        for (int k = 0; k < nbl; k++) begin
            r_i = 8'($urandom); g_i = 8'($urandom); b_i = 8'($urandom);
            de_i = 1'b0; hsync_i = (k >= 4 && k < 20);
            vsync_i = !(vs_fall && k < 3);
            osd_enable = 1'($urandom); osd_color = 1'($urandom);
            step();
        end
    endtask

    task automatic burst(input int n, input logic [7:0] val, input logic de,
                         input logic en, input logic col);
        r_i = val; g_i = val; b_i = val;
        de_i = de; hsync_i = 1'b0; vsync_i = 1'b1;
        osd_enable = en; osd_color = col;
        repeat (n) step();
    endtask

    initial begin
        rst_i = 1'b1;
        r_i = 0; g_i = 0; b_i = 0;
        hsync_i = 0; vsync_i = 1; de_i = 0;
        osd_enable = 0; osd_color = 0; fg_rgb = 0;
        repeat (3) step();
        chk("reset_out", 32'({r_o, g_o, b_o, hsync_o, vsync_o, de_o}), 0);
        chk("reset_pos", 32'({xpos, ypos}), 0);
        rst_i = 1'b0;

        line(0, 40, 0, 1);
        line(640, 160, 0, 0);
        line(640, 160, 1, 0);
        line(640, 160, 2, 0);
        line(0, 40, 0, 1);
        line(640, 160, 0, 0);

        osd_enable = 0; osd_color = 0;
        for (int i = 0; i < 30; i++) begin
            de_i = (i < 20); r_i = (i == 5) ? 8'hAB : 8'h00;
            g_i = 8'($urandom); b_i = 8'($urandom);
            hsync_i = (i == 5); vsync_i = 1'b1;
            step();
            if (i == 11 || i == 13) chk("mark_neighbour", 32'({r_o, hsync_o}), 0);
            if (i == 12) begin
                chk("mark_r", 32'(r_o), 32'hAB);
                chk("mark_de", 32'(de_o), 1);
                chk("mark_hs", 32'(hsync_o), 1);
            end
        end

        fg_rgb = 24'hFFFFFF;
        burst(12, 8'hC8, 1, 1, 1);
        chk("fg_white", 32'({r_o, g_o, b_o}), 32'hFFFFFF);
        burst(12, 8'hC8, 1, 1, 0);
        chk("bg_dim", 32'({r_o, g_o, b_o}), 32'h646464);
        burst(12, 8'hC8, 1, 0, 0);
        chk("pass_thru", 32'({r_o, g_o, b_o}), 32'hC8C8C8);
        burst(12, 8'hC8, 0, 1, 1);
        chk("off_de_rgb", 32'({r_o, g_o, b_o}), 0);
        chk("off_de_de", 32'(de_o), 0);

        line(0, 40, 0, 1);
        line(2100, 50, 0, 1);
        line(100, 20, 0, 0);

        for (int k = 0; k < 30; k++) begin
            r_i = 8'($urandom) | 8'h01; g_i = 8'($urandom); b_i = 8'($urandom);
            de_i = 1'b1; hsync_i = 1'b0; vsync_i = 1'b1;
            osd_enable = 1'b0; osd_color = 1'b0;
            step();
        end
        #2 rst_i = 1'b1;
        #1;
        chk("rst_async_out", 32'({r_o, g_o, b_o, hsync_o, vsync_o, de_o}), 0);
        chk("rst_async_pos", 32'({xpos, ypos}), 0);
        step();
        step();
        rst_i = 1'b0;
        line(50, 20, 0, 0);

        burst(10, 8'h00, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
